enemy_roster: RTL and testbench

- Owns the live state of all 23 enemy slots; the consumer end of the stage spawn interface.
- Accepts per-group spawn pulses (reset_fly / reset_spider / reset_mosquito) plus the spawn alive mask, and reports enemy_alive_out.
- Applies hits from the collision unit through a valid/ready handshake, tracks per-slot hit points, and emits kill events and group-cleared pulses to scoring/UI.

---
 rtl/enemy_pkg.sv | 40 ++++
 rtl/enemy_slot.sv | 71 +++++++
 rtl/enemy_roster.sv | 120 ++++++++++++
 tb/tb_enemy_roster.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// enemy_pkg: slot-to-group map, kill_type codes and default hit points
// shared by the enemy roster and its per-slot registers.
package enemy_pkg;

    localparam int IDX_W     = 5;
    localparam int NUM_SLOTS = 23;

    // Fixed group map: flies, then spiders, then mosquitoes.
    localparam int FLY_FIRST    = 0;
    localparam int FLY_LAST     = 16;
    localparam int SPIDER_FIRST = 17;
    localparam int SPIDER_LAST  = 20;
    localparam int MOSQ_FIRST   = 21;
    localparam int MOSQ_LAST    = 22;

    localparam logic [NUM_SLOTS-1:0] FLY_MASK    = 23'h01_FFFF;
    localparam logic [NUM_SLOTS-1:0] SPIDER_MASK = 23'h1E_0000;
    localparam logic [NUM_SLOTS-1:0] MOSQ_MASK   = 23'h60_0000;

    // kill_type codes reported with each kill event.
    localparam logic [1:0] KT_NONE   = 2'b00;
    localparam logic [1:0] KT_FLY    = 2'b01;
    localparam logic [1:0] KT_SPIDER = 2'b10;
    localparam logic [1:0] KT_MOSQ   = 2'b11;

    localparam int DEF_FLY_HP    = 1;
    localparam int DEF_SPIDER_HP = 3;
    localparam int DEF_MOSQ_HP   = 5;

    localparam int DEF_FLASH_CYCLES = 3_125_000;

    // Group code of a slot index; indices past the last slot map to mosquito
    // but are filtered out before they can reach any slot.
    function automatic logic [1:0] slot_type(logic [IDX_W-1:0] idx);
        if (int'(idx) <= FLY_LAST)         return KT_FLY;
        else if (int'(idx) <= SPIDER_LAST) return KT_SPIDER;
        else                               return KT_MOSQ;
    endfunction

endpackage

// File: rtl/enemy_slot.sv
// enemy_slot: alive bit and hit-point counter for one enemy slot.
// Spawn takes priority over a hit in the same cycle. Optional macro
// ENEMY_HIT_FLASH_EN adds a per-slot hit-flash countdown.
module enemy_slot
    import enemy_pkg::*;
#(
    parameter logic [2:0] HP           = 3'd1,
    parameter int         FLASH_CYCLES = DEF_FLASH_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_spawn,
    input  logic i_spawn_alive,
    input  logic i_hit,
`ifdef ENEMY_HIT_FLASH_EN
    output logic o_flash,
`endif
    output logic o_alive,
    output logic o_fatal
);

    logic       r_alive;
    logic [2:0] r_hp;
    logic       w_apply;
    logic       w_fatal;

    // A hit only lands on a live slot whose group is not respawning.
    assign w_apply = i_hit & r_alive & ~i_spawn;
    assign w_fatal = w_apply & (r_hp <= 3'd1);

    assign o_alive = r_alive;
    assign o_fatal = w_fatal;

    // Alive/hp update: spawn reload, fatal clear, or one-point decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
            r_hp    <= 3'd0;
        end else if (i_spawn) begin
            r_alive <= i_spawn_alive;
            r_hp    <= i_spawn_alive ? HP : 3'd0;
        end else if (w_fatal) begin
            r_alive <= 1'b0;
            r_hp    <= 3'd0;
        end else if (w_apply) begin
            r_hp    <= r_hp - 3'd1;
        end
    end

`ifdef ENEMY_HIT_FLASH_EN
    localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

    logic [FLASH_W-1:0] r_flash_cnt;

    assign o_flash = (r_flash_cnt != '0);

    // Flash countdown: (re)loaded by a surviving hit, cleared by kill or spawn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flash_cnt <= '0;
        end else if (i_spawn || w_fatal) begin
            r_flash_cnt <= '0;
        end else if (w_apply) begin
            r_flash_cnt <= FLASH_W'(FLASH_CYCLES - 1);
        end else if (r_flash_cnt != '0) begin
            r_flash_cnt <= r_flash_cnt - 1'b1;
        end
    end
`endif

endmodule

// File: rtl/enemy_roster.sv
// enemy_roster: live state of all enemy slots. Takes spawn pulses and hits,
// emits buffered kill events and per-group cleared pulses.
// Optional macro ENEMY_HIT_FLASH_EN adds the enemy_flash output.
module enemy_roster
    import enemy_pkg::*;
#(
    parameter int ENEMY_COUNT  = NUM_SLOTS,
    parameter int FLY_HP       = DEF_FLY_HP,
    parameter int SPIDER_HP    = DEF_SPIDER_HP,
    parameter int MOSQ_HP      = DEF_MOSQ_HP,
    parameter int FLASH_CYCLES = DEF_FLASH_CYCLES
) (
    input  logic                   clk25,
    input  logic                   global_reset_n,
    input  logic [ENEMY_COUNT-1:0] enemy_alive_in,
    input  logic                   reset_fly,
    input  logic                   reset_spider,
    input  logic                   reset_mosquito,
    input  logic                   hit_valid,
    input  logic [IDX_W-1:0]       hit_idx,
    output logic                   hit_ready,
    output logic [ENEMY_COUNT-1:0] enemy_alive_out,
    output logic                   kill_valid,
    input  logic                   kill_ready,
    output logic [IDX_W-1:0]       kill_idx,
    output logic [1:0]             kill_type,
`ifdef ENEMY_HIT_FLASH_EN
    output logic [ENEMY_COUNT-1:0] enemy_flash,
`endif
    output logic [2:0]             group_cleared,
    output logic                   all_dead
);

    logic                   r_kill_valid;
    logic [IDX_W-1:0]       r_kill_idx;
    logic [1:0]             r_kill_type;
    logic [2:0]             r_group_cleared;

    logic                   w_accept;
    logic                   w_idx_ok;
    logic                   w_any_fatal;
    logic [ENEMY_COUNT-1:0] w_spawn;
    logic [ENEMY_COUNT-1:0] w_hit;
    logic [ENEMY_COUNT-1:0] w_fatal;
    logic [ENEMY_COUNT-1:0] w_alive;
    logic [ENEMY_COUNT-1:0] w_left;
    logic [2:0]             w_cleared;

    // The one-entry kill buffer back-pressures hits only while it is full
    // and not being drained this cycle.
    assign hit_ready   = ~r_kill_valid | kill_ready;
    assign w_accept    = hit_valid & hit_ready;
    assign w_idx_ok    = (int'(hit_idx) < ENEMY_COUNT);
    assign w_any_fatal = |w_fatal;

    generate
        for (genvar gi = 0; gi < ENEMY_COUNT; gi++) begin : g_slot
            localparam logic [1:0] TYPE = slot_type(IDX_W'(gi));
            localparam logic [2:0] HP   = (TYPE == KT_FLY)    ? 3'(FLY_HP)    :
                                          (TYPE == KT_SPIDER) ? 3'(SPIDER_HP) :
                                                                3'(MOSQ_HP);

            assign w_spawn[gi] = (TYPE == KT_FLY)    ? reset_fly    :
                                 (TYPE == KT_SPIDER) ? reset_spider :
                                                       reset_mosquito;
            assign w_hit[gi]   = w_accept & w_idx_ok & (hit_idx == IDX_W'(gi));

            enemy_slot #(
                .HP           (HP),
                .FLASH_CYCLES (FLASH_CYCLES)
            ) u_slot (
                .clk           (clk25),
                .rst_n         (global_reset_n),
                .i_spawn       (w_spawn[gi]),
                .i_spawn_alive (enemy_alive_in[gi]),
                .i_hit         (w_hit[gi]),
`ifdef ENEMY_HIT_FLASH_EN
                .o_flash       (enemy_flash[gi]),
`endif
                .o_alive       (w_alive[gi]),
                .o_fatal       (w_fatal[gi])
            );
        end
    endgenerate

    // A group clears when this cycle's kill takes its last survivor.
    assign w_left       = w_alive & ~w_fatal;
    assign w_cleared[0] = |(w_fatal & FLY_MASK)    & ~|(w_left & FLY_MASK);
    assign w_cleared[1] = |(w_fatal & SPIDER_MASK) & ~|(w_left & SPIDER_MASK);
    assign w_cleared[2] = |(w_fatal & MOSQ_MASK)   & ~|(w_left & MOSQ_MASK);

    // Kill buffer: load on a fatal hit, drop on handshake, else hold.
    always_ff @(posedge clk25 or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_kill_valid <= 1'b0;
            r_kill_idx   <= '0;
            r_kill_type  <= KT_NONE;
        end else if (w_any_fatal) begin
            r_kill_valid <= 1'b1;
            r_kill_idx   <= hit_idx;
            r_kill_type  <= slot_type(hit_idx);
        end else if (r_kill_valid && kill_ready) begin
            r_kill_valid <= 1'b0;
        end
    end

    // Group-cleared pulses live for exactly one cycle.
    always_ff @(posedge clk25 or negedge global_reset_n) begin
        if (!global_reset_n) r_group_cleared <= 3'b000;
        else                 r_group_cleared <= w_cleared;
    end

    assign enemy_alive_out = w_alive;
    assign kill_valid      = r_kill_valid;
    assign kill_idx        = r_kill_idx;
    assign kill_type       = r_kill_type;
    assign group_cleared   = r_group_cleared;
    assign all_dead        = ~|w_alive;

endmodule

// File: tb/tb_enemy_roster.sv
// tb_enemy_roster: directed test-plan sequence plus randomized traffic,
// each cycle compared against a slot-array reference model.
module tb_enemy_roster;

    logic        clk25 = 1'b0;
    logic        global_reset_n = 1'b0;
    logic [22:0] enemy_alive_in = '0;
    logic        reset_fly = 1'b0, reset_spider = 1'b0, reset_mosquito = 1'b0;
    logic        hit_valid = 1'b0;
    logic [4:0]  hit_idx = '0;
    logic        hit_ready;
    logic [22:0] enemy_alive_out;
    logic        kill_valid;
    logic        kill_ready = 1'b1;
    logic [4:0]  kill_idx;
    logic [1:0]  kill_type;
    logic [2:0]  group_cleared;
    logic        all_dead;
`ifdef ENEMY_HIT_FLASH_EN
    logic [22:0] enemy_flash;
`endif

    enemy_roster dut (
        .clk25           (clk25),
        .global_reset_n  (global_reset_n),
        .enemy_alive_in  (enemy_alive_in),
        .reset_fly       (reset_fly),
        .reset_spider    (reset_spider),
        .reset_mosquito  (reset_mosquito),
        .hit_valid       (hit_valid),
        .hit_idx         (hit_idx),
        .hit_ready       (hit_ready),
        .enemy_alive_out (enemy_alive_out),
        .kill_valid      (kill_valid),
        .kill_ready      (kill_ready),
        .kill_idx        (kill_idx),
        .kill_type       (kill_type),
`ifdef ENEMY_HIT_FLASH_EN
        .enemy_flash     (enemy_flash),
`endif
        .group_cleared   (group_cleared),
        .all_dead        (all_dead)
    );

    always #20 clk25 = ~clk25;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: plain per-slot arrays.
    bit       m_alive [23];
    int       m_hp    [23];
    bit       m_kv;
    int       m_kidx;
    int       m_kt;
    bit [2:0] m_gc;
    int       grp_hp [3] = '{1, 3, 5};

    function automatic int grp(int i);
        if (i <= 16) return 0;
        if (i <= 20) return 1;
        return 2;
    endfunction

    function automatic logic [22:0] m_vec();
        logic [22:0] v = '0;
        for (int i = 0; i < 23; i++) v[i] = m_alive[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 23; i++) begin
            m_alive[i] = 0;
            m_hp[i]    = 0;
        end
        m_kv = 0; m_kidx = 0; m_kt = 0; m_gc = 0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".alive"},    32'(enemy_alive_out), 32'(m_vec()));
        chk({tag, ".kv"},       32'(kill_valid),      32'(m_kv));
        chk({tag, ".kidx"},     32'(kill_idx),        32'(m_kidx));
        chk({tag, ".ktype"},    32'(kill_type),       32'(m_kt));
        chk({tag, ".gc"},       32'(group_cleared),   32'(m_gc));
        chk({tag, ".all_dead"}, 32'(all_dead),        32'(m_vec() == 0));
    endtask

    // One clock: drive inputs, check ready, advance model, check outputs.
    // Entered and left at posedge+1.
    task automatic step(bit hv, int idx, bit kr, bit rf, bit rs, bit rm,
                        logic [22:0] mask);
        bit acc;
        bit spw [3];
        int g;
        hit_valid = hv; hit_idx = 5'(idx); kill_ready = kr;
        reset_fly = rf; reset_spider = rs; reset_mosquito = rm;
        enemy_alive_in = mask;
        #1;
        chk("hit_ready", 32'(hit_ready), 32'(!m_kv || kr));
        acc = hv && (!m_kv || kr);
        spw[0] = rf; spw[1] = rs; spw[2] = rm;
        m_gc = 0;
        if (m_kv && kr) m_kv = 0;
        if (acc && idx < 23) begin
            g = grp(idx);
            if (m_alive[idx] && !spw[g]) begin
                if (m_hp[idx] > 1) m_hp[idx]--;
                else begin
                    bit any = 0;
                    m_hp[idx] = 0; m_alive[idx] = 0;
                    m_kv = 1; m_kidx = idx; m_kt = g + 1;
                    for (int i = 0; i < 23; i++)
                        if (grp(i) == g && m_alive[i]) any = 1;
                    if (!any) m_gc[g] = 1;
                end
            end
        end
        for (int i = 0; i < 23; i++)
            if (spw[grp(i)]) begin
                m_alive[i] = mask[i];
                m_hp[i]    = mask[i] ? grp_hp[grp(i)] : 0;
            end
        @(posedge clk25); #1;
        chk_all("step");
    endtask

    task automatic hit(int idx, bit kr);
        step(1, idx, kr, 0, 0, 0, '0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk25);
        @(negedge clk25);
        chk_all("reset");
        chk("reset.hit_ready", 32'(hit_ready), 32'd1);
        global_reset_n = 1'b1;
        @(posedge clk25); #1;

        // Fly spawn with a full mask.
        step(0, 0, 1, 1, 0, 0, 23'h01FFFF);
        chk("fly_spawn.alive", 32'(enemy_alive_out), 32'h01FFFF);
        chk("fly_spawn.all_dead", 32'(all_dead), 32'd0);
        chk("fly_spawn.kv", 32'(kill_valid), 32'd0);

        // Spider spawn, three hits on slot 18.
        step(0, 0, 1, 0, 1, 0, 23'h1E0000);
        hit(18, 1);
        chk("spider.hit1", 32'(enemy_alive_out[18]), 32'd1);
        hit(18, 1);
        chk("spider.hit2", 32'(enemy_alive_out[18]), 32'd1);
        hit(18, 1);
        chk("spider.kill.alive", 32'(enemy_alive_out[18]), 32'd0);
        chk("spider.kill.kv",    32'(kill_valid), 32'd1);
        chk("spider.kill.idx",   32'(kill_idx),   32'd18);
        chk("spider.kill.type",  32'(kill_type),  32'd2);

        // Mosquito group: kill 21 then 22, cleared only on the second.
        step(0, 0, 1, 0, 0, 1, 23'h600000);
        repeat (5) hit(21, 1);
        chk("mosq.first.gc", 32'(group_cleared), 32'd0);
        repeat (5) hit(22, 1);
        chk("mosq.second.gc", 32'(group_cleared), 32'd4);
        step(0, 0, 1, 0, 0, 0, '0);
        chk("mosq.gc_pulse", 32'(group_cleared), 32'd0);

        // Back-pressure: kill 3 held, hit 4 stalled, then back-to-back.
        hit(3, 0);
        chk("bp.kidx3", 32'(kill_idx), 32'd3);
        hit(4, 0);
        chk("bp.stall.alive4", 32'(enemy_alive_out[4]), 32'd1);
        chk("bp.stall.kidx", 32'(kill_idx), 32'd3);
        hit(4, 1);
        chk("bp.kidx4", 32'(kill_idx), 32'd4);
        chk("bp.kv", 32'(kill_valid), 32'd1);
        step(0, 0, 1, 0, 0, 0, '0);

        // Spawn wins over a same-cycle hit; out-of-range and dead hits drop.
        step(1, 5, 1, 1, 0, 0, 23'h01FFFF);
        chk("spawnwin.alive5", 32'(enemy_alive_out[5]), 32'd1);
        chk("spawnwin.kv", 32'(kill_valid), 32'd0);
        hit(25, 1);
        hit(18, 1);
        chk("drop.kv", 32'(kill_valid), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            int idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                  : int'($urandom_range(0, 22));
            step(bit'($urandom_range(0, 1)), idx, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0, 23'($urandom));
        end

        // Async reset with a pending kill.
        step(0, 0, 1, 1, 0, 0, 23'h01FFFF);
        hit(0, 0);
        chk("pre_rst.kv", 32'(kill_valid), 32'd1);
        #2 global_reset_n = 1'b0;
        #2;
        model_reset();
        chk("async_rst.kv", 32'(kill_valid), 32'd0);
        chk("async_rst.alive", 32'(enemy_alive_out), 32'd0);
        chk("async_rst.all_dead", 32'(all_dead), 32'd1);
        @(negedge clk25);
        global_reset_n = 1'b1;
        @(posedge clk25); #1;
        step(0, 0, 0, 0, 0, 0, '0);
        step(0, 0, 1, 1, 1, 1, 23'h7FFFFF);
        hit(20, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
